// File: rtl/video_timing_out.sv
// video_timing_out
//   Pixel-stream to LCD/VGA timing engine. Incoming pixels (valid/ready with a
//   start-of-frame marker) are buffered in a small FIFO and replayed into the
//   active area of a raster. The raster timing, colour depth and sync polarity
//   are all set by parameters.
//   Line order is active, front porch, sync, back porch. Frame order is the
//   same, counted in lines.
//
//   Ports
//     clk              pixel clock
//     reset            synchronous, active-high
//     enable           run request, sampled at frame boundaries
//     sink_data        pixel {R,G,B}, 3*BPC bits
//     sink_valid       pixel present on sink_data
//     sink_sop         sink_data is the first pixel of a frame
//     sink_ready       FIFO can accept a word
//     video_RGB_OUT    registered pixel out; 0 whenever DEN is low
//     video_HD/VD      registered syncs; active level is HS_POL/VS_POL
//     video_DEN        registered data enable (raster active area)
//     frame_done       pulse aligned with the output of the last raster slot
//     underflow_count  saturating count of active slots filled black on empty
module video_timing_out #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 25,
  parameter int BPC        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3*BPC-1:0] sink_data,
  input  logic             sink_valid,
  input  logic             sink_sop,
  output logic             sink_ready,
  output logic [3*BPC-1:0] video_RGB_OUT,
  output logic             video_HD,
  output logic             video_VD,
  output logic             video_DEN,
  output logic             frame_done,
  output logic [15:0]      underflow_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = 3 * BPC;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef struct packed {
    logic          sop;
    logic [DW-1:0] data;
  } px_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESYNC} state_t;

  // ---------------------------------------------------------------- FIFO
  px_t           mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          ready_en;   // holds sink_ready low through the reset cycle
  logic          empty, full, push, pop;
  px_t           head;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign sink_ready = ready_en && !full;
  assign push       = sink_valid && sink_ready;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{sop: sink_sop, data: sink_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------- raster
  state_t        state, state_n;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          blank, blank_n;  // rest of frame black after an early sop
  logic          running, active, origin, last, uf_inc;
  logic [DW-1:0] pix;

  assign running = (state != S_IDLE);
  assign active  = (h < H_ACT) && (v < V_ACT);
  assign origin  = (h == '0) && (v == '0);
  assign last    = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge clk) begin
    if (reset || !running) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      blank <= 1'b0;
    end else begin
      state <= state_n;
      blank <= blank_n;
    end
  end

  always_comb begin
    state_n = state;
    blank_n = blank;
    pop     = 1'b0;
    uf_inc  = 1'b0;
    pix     = '0;
    case (state)
      S_IDLE: if (enable) state_n = S_RUN;
      S_RUN: begin
        if (active && !blank) begin
          if (empty) begin
            uf_inc = 1'b1;
          end else if (origin) begin
            // A frame must start on a sop word; otherwise hunt for one.
            if (head.sop) begin
              pop = 1'b1;
              pix = head.data;
            end else begin
              state_n = S_RESYNC;
            end
          end else if (head.sop) begin
            // Next frame arrived early: keep it for (0,0), blank the rest.
            blank_n = 1'b1;
          end else begin
            pop = 1'b1;
            pix = head.data;
          end
        end
        if (last) begin
          blank_n = 1'b0;
          state_n = enable ? S_RUN : S_IDLE;
        end
      end
      S_RESYNC: begin
        // Drain stale words on every cycle; a sop word stays at the head.
        if (!empty && !head.sop) pop = 1'b1;
        if (last) state_n = enable ? S_RUN : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      video_DEN     <= 1'b0;
      video_RGB_OUT <= '0;
      video_HD      <= !HS_POL;
      video_VD      <= !VS_POL;
      frame_done    <= 1'b0;
    end else begin
      video_DEN     <= running && active;
      video_RGB_OUT <= pix;
      video_HD      <= (running && h >= H_SS && h < H_SE) ? HS_POL : !HS_POL;
      video_VD      <= (running && v >= V_SS && v < V_SE) ? VS_POL : !VS_POL;
      frame_done    <= running && last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                   underflow_count <= '0;
    else if (uf_inc && underflow_count != '1)    underflow_count <= underflow_count + 16'd1;
  end

endmodule

// File: tb/tb_video_timing_out.sv
// tb_video_timing_out
//   Directed bench for video_timing_out with an 8x6 raster (4 active pixels,
//   3 active lines). A table of frames gives the words fed in and the twelve
//   pixels expected in the active area; every output cycle of each frame is
//   compared against the raster position derived from the cycle index.
module tb_video_timing_out;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] sink_data = '0;
  logic          sink_valid = 1'b0;
  logic          sink_sop = 1'b0;
  logic          sink_ready;
  logic [DW-1:0] video_RGB_OUT;
  logic          video_HD, video_VD, video_DEN, frame_done;
  logic [15:0]   underflow_count;

  video_timing_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BPC(8), .FIFO_DEPTH(8), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_ready(sink_ready), .video_RGB_OUT(video_RGB_OUT),
    .video_HD(video_HD), .video_VD(video_VD), .video_DEN(video_DEN),
    .frame_done(frame_done), .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          start;     // begin from IDLE: preload, then raise enable
    int          n_pre;
    logic [24:0] pre[12];   // {sop, data}
    int          n_inj;     // words queued mid-frame, after the active area
    logic [24:0] inj[17];
    logic [23:0] pix[12];   // expected active-area pixels, raster order
    logic [15:0] uf;        // expected underflow_count after the frame
    bit          keep;      // keep enable high into the next frame
  } frame_t;

  frame_t      tv[7];
  int          n_vec = 0;
  int          n_err = 0;
  logic [24:0] fq[$];
  bit          will_push = 1'b0;

  // Feeder: drives the queue head, drops it once the DUT has taken it.
  initial forever begin
    @(negedge clk);
    will_push = sink_valid && sink_ready;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (will_push && fq.size() > 0) void'(fq.pop_front());
    sink_valid = (fq.size() > 0);
    if (fq.size() > 0) {sink_sop, sink_data} = fq[0];
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs;
    return {4'b0, frame_done, video_DEN, video_HD, video_VD, video_RGB_OUT};
  endfunction

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      chk($sformatf("idle%0d", i), outs(), {4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0});
    end
  endtask

  task automatic run_frame(input int k);
    int h, v;
    logic act;
    logic [31:0] e;
    for (int i = 0; i < 48; i++) begin
      tick;
      h   = i % 8;
      v   = i / 8;
      act = (h < 4) && (v < 3);
      e   = {4'b0, 1'(i == 47), act, 1'(!(h == 5 || h == 6)), 1'(v != 4),
             act ? tv[k].pix[v*4 + h] : 24'h0};
      chk($sformatf("frame%0d slot%0d", k, i), outs(), e);
      if (i == 20 && !tv[k].keep) enable = 1'b0;
      if (i == 24) for (int j = 0; j < tv[k].n_inj; j++) fq.push_back(tv[k].inj[j]);
    end
    chk($sformatf("frame%0d underflow", k), 32'(underflow_count), 32'(tv[k].uf));
  endtask

  initial begin
    for (int k = 0; k < 7; k++) begin
      tv[k].start = 1'b0; tv[k].n_pre = 0; tv[k].n_inj = 0;
      tv[k].keep = 1'b1;  tv[k].uf = 16'd2;
      for (int j = 0; j < 12; j++) tv[k].pix[j] = 24'h0;
    end
    // 0: clean 12-pixel frame from preload; enable dropped mid-frame
    tv[0].start = 1'b1; tv[0].n_pre = 12; tv[0].uf = 16'd0; tv[0].keep = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tv[0].pre[j] = {1'(j == 0), 24'(j + 1)};
      tv[0].pix[j] = 24'(j + 1);
    end
    // 1: only 10 pixels, last two slots underflow; late junk + next frame queued
    tv[1].start = 1'b1; tv[1].n_pre = 10; tv[1].n_inj = 15;
    for (int j = 0; j < 10; j++) begin
      tv[1].pre[j] = {1'(j == 0), 24'(32'h21 + j)};
      tv[1].pix[j] = 24'(32'h21 + j);
    end
    for (int j = 0; j < 3; j++)  tv[1].inj[j]     = {1'b0, 24'(32'hEE0001 + j)};
    for (int j = 0; j < 12; j++) tv[1].inj[3 + j] = {1'(j == 0), 24'(32'h31 + j)};
    // 2: head lacks sop at (0,0): resync frame, all black
    // 3: realigned frame; queue a short 5-pixel frame followed by a full one
    tv[3].n_inj = 17;
    for (int j = 0; j < 12; j++) tv[3].pix[j] = 24'(32'h31 + j);
    for (int j = 0; j < 5; j++)  tv[3].inj[j]     = {1'(j == 0), 24'(32'h41 + j)};
    for (int j = 0; j < 12; j++) tv[3].inj[5 + j] = {1'(j == 0), 24'(32'h51 + j)};
    // 4: sop at head in slot 5: remaining slots black, not underflow
    for (int j = 0; j < 5; j++) tv[4].pix[j] = 24'(32'h41 + j);
    // 5: the early sop frame shows from (0,0); stop afterwards
    tv[5].keep = 1'b0;
    for (int j = 0; j < 12; j++) tv[5].pix[j] = 24'(32'h51 + j);
    // 6: after a mid-frame reset, empty FIFO: 12 underflows
    tv[6].start = 1'b1; tv[6].uf = 16'd12; tv[6].keep = 1'b0;

    // Reset values
    repeat (3) tick;
    chk("reset outs", outs(), {4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0});
    chk("reset ready/uf", {15'b0, sink_ready, underflow_count}, 32'h0);
    reset = 1'b0;
    tick;
    chk("ready after reset", 32'(sink_ready), 32'h1);

    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        // Mid-frame reset with data in flight
        for (int j = 0; j < 4; j++) fq.push_back({1'(j == 0), 24'(32'h61 + j)});
        repeat (6) tick;
        enable = 1'b1;
        tick;
        tick;
        chk("pre-reset slot0", outs(), {4'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h61});
        reset  = 1'b1;
        enable = 1'b0;
        tick;
        chk("mid reset outs", outs(), {4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0});
        chk("mid reset ready/uf", {15'b0, sink_ready, underflow_count}, 32'h0);
        reset = 1'b0;
        tick;
        chk("ready after mid reset", 32'(sink_ready), 32'h1);
      end
      if (tv[k].start) begin
        for (int j = 0; j < tv[k].n_pre; j++) fq.push_back(tv[k].pre[j]);
        repeat (12) tick;
        chk($sformatf("frame%0d preload ready", k), 32'(sink_ready), 32'(tv[k].n_pre < 8));
        enable = 1'b1;
        tick;
      end
      run_frame(k);
      if (!tv[k].keep) idle_chk(4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_out.md
# video_timing_out

Parametrised video output engine for the LCD/VGA path. Replaces the fixed-resolution video output of the system with configurable timing, colour depth and sync polarity. Accepts a pixel stream (valid/ready, start-of-frame marker) into an internal FIFO and drives RGB, HD, VD and DEN. Adds frame realignment, underflow handling with black fill, and a saturating underflow counter.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal front porch / sync / back porch, in pixels (each ≥1)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 1 / 3 / 25, vertical porch/sync widths, in lines (each ≥1)
- BPC, 8, bits per colour channel; RGB width is 3*BPC
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, ≥4)
- HS_POL / VS_POL, 0 / 0, active level of HD / VD

Ports:
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- enable  in  1  run request; checked at frame boundaries
- sink_data  in  3*BPC  pixel, {R,G,B}
- sink_valid  in  1  pixel present
- sink_sop  in  1  marks the first pixel of a frame
- sink_ready  out  1  FIFO not full
- video_RGB_OUT  out  3*BPC  pixel out
- video_HD  out  1  horizontal sync
- video_VD  out  1  vertical sync
- video_DEN  out  1  data enable
- frame_done  out  1  one-cycle pulse at the last pixel slot of a frame
- underflow_count  out  16  saturating count of black-filled active slots

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. A frame lasts H_TOTAL*V_TOTAL cycles.
- Counters: h runs 0..H_TOTAL-1 and wraps; v increments on h wrap, runs 0..V_TOTAL-1 and wraps.
- Line order is active, FP, sync, BP.
  - Active slot: h<H_ACTIVE and v<V_ACTIVE.
  - HD is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line.
  - VD is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, over whole lines.
- FIFO:
  - Push when sink_valid && sink_ready; sink_ready = !full.
  - Each entry stores {sop, data}.
  - A pushed word becomes poppable on the next cycle.
- States:
  - IDLE: counters held at 0; outputs idle. Goes to RUN when enable=1.
  - RUN: each active slot pops one FIFO word and outputs it.
    - At slot (0,0): if the head word lacks sop, go to RESYNC; the slot is not popped and is output black.
    - Empty FIFO in an active slot: output black, no pop, underflow_count +1 (saturates at 65535).
    - Head word has sop at an active slot other than (0,0): do not pop; output black for the rest of the frame's active slots. These slots are not counted as underflow.
  - RESYNC: timing continues and outputs black on active slots. Non-sop head words are popped and discarded, one per cycle. A sop at the head is held. Go to RUN at the next (0,0).
- enable=0 in RUN/RESYNC: the current frame completes; the state goes to IDLE on the cycle after the last slot (H_TOTAL-1, V_TOTAL-1).
- DEN follows the active slot regardless of data availability.

## Timing
- Reset values:
  - video_DEN=0, video_RGB_OUT=0
  - video_HD=!HS_POL, video_VD=!VS_POL
  - frame_done=0, underflow_count=0, sink_ready=0
  - FIFO flushed, state IDLE
- sink_ready goes to 1 the cycle after reset deasserts. Reset asserted mid-frame takes effect at that edge, with no frame completion.
- All video outputs are registered. Outputs for counter position (h,v) appear one cycle after the counters hold (h,v).
- Enable latency: if enable is sampled 1 at edge E0 in IDLE, the counters are (0,0) after E0 and the first DEN=1 is visible after E1.
- frame_done is high for the single output cycle of slot (H_TOTAL-1, V_TOTAL-1).
- RGB is 0 whenever DEN=0.

## Test plan
Small parameters for all scenarios: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), BPC=8, FIFO_DEPTH=8, polarities 0.
1. Preload 12 pixels 0x000001..0x00000C (first with sop), then enable=1. Required:
   - DEN pulses of 4 cycles per line, on 3 lines, carrying pixels 1..12 in order.
   - HD low on h=5,6 of every line; VD low for line 4.
   - frame_done pulses once per 48 cycles; underflow_count=0.
2. Supply only 10 pixels. Required:
   - Slots 11 and 12 output 0x000000 with DEN=1; underflow_count=2.
   - The next frame's (0,0) head lacks sop, so the block enters RESYNC.
3. Push 3 junk words, then a 12-pixel sop frame. Required:
   - First frame all black; junk words discarded.
   - Second frame shows pixels 1..12.
4. A sop word is at the head at slot 6. Required:
   - Slots 6..12 output black with underflow_count unchanged.
   - The sop pixel appears at (0,0) of the next frame.
5. Drop enable mid-frame. Required:
   - The frame completes and frame_done pulses.
   - Then DEN stays 0, HD=VD=1.
6. Stall the sink past FIFO_DEPTH. Required:
   - sink_ready=0 at 8 entries; no word lost or duplicated.
   - A reset pulse mid-frame gives the reset values on the next cycle.
